spi_frame_arbiter: RTL and testbench

Round-robin arbiter that shares one SPI serializer among NUM_CH requesters. It latches a requester's word and drives the serializer's load handshake. It tracks the frame to completion and routes the serializer's single chip select to a per-channel chip-select line. It sits between the per-device command logic and the serializer instance.

---
 rtl/spi_arb_pkg.sv | 14 +
 rtl/spi_frame_arbiter_rr_pick.sv | 37 +++
 rtl/spi_frame_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_frame_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI frame arbiter: FSM state encoding and round-robin pointer width.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Pointer is sized for the largest supported channel count so every NUM_CH shares one width.
    localparam int unsigned MAX_CH = 16;
    localparam int unsigned PTR_W  = $clog2(MAX_CH);

endpackage

// File: rtl/spi_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible channel searching upward from last+1, wrapping.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [PTR_W-1:0]  last,
    output logic [NUM_CH-1:0] winner,
    output logic [PTR_W-1:0]  winner_idx,
    output logic              any_valid
);

    logic [31:0]    elig_ext;
    logic [PTR_W:0] cand;

    assign elig_ext = 32'(eligible);

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (PTR_W+1)'(last) + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_CH)) begin
                cand = cand - (PTR_W+1)'(NUM_CH);
            end
            if (!any_valid && elig_ext[cand]) begin
                any_valid  = 1'b1;
                winner     = NUM_CH'(1) << cand;
                winner_idx = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Shares one SPI serializer among NUM_CH requesters: round-robin grant, load handshake,
// frame tracking with ISSUE timeout, and per-channel chip-select routing.
//
//   state | meaning
//   IDLE  | no frame owned; arbitrate when serializer ready and a channel is eligible
//   ISSUE | word latched, load request held until serializer drops ready (or timeout)
//   BUSY  | serializer shifting the frame; wait for ready to return, then pulse done
module spi_frame_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [NUM_CH-1:0]           i_Enable,
    input  logic [NUM_CH-1:0]           i_Req,
    input  logic [NUM_CH*DATA_SIZE-1:0] i_Data,
    output logic [NUM_CH-1:0]           o_Grant,
    output logic [NUM_CH-1:0]           o_Done,
    output logic                        o_Timeout,
    output logic                        o_Ser_Data_Ready,
    output logic [DATA_SIZE-1:0]        o_Ser_Data,
    input  logic                        i_Ser_Ready,
    input  logic                        i_Ser_CS,
    output logic [NUM_CH-1:0]           o_CS
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    arb_state_t          state, state_nxt;
    logic [NUM_CH-1:0]   grant_r;
    logic [PTR_W-1:0]    last_r;
    logic [TW-1:0]       tmo_cnt;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   winner;
    logic [PTR_W-1:0]    winner_idx;
    logic                any_valid;
    logic [DATA_SIZE-1:0] winner_data;
    logic                tmo_hit;

    logic [NUM_CH-1:0]   grant_pulse_nxt;
    logic [NUM_CH-1:0]   done_nxt;
    logic                tmo_nxt;
    logic                data_ready_nxt;
    logic                load_word;
    logic                grant_clr;

    assign eligible = i_Req & i_Enable;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .eligible   (eligible),
        .last       (last_r),
        .winner     (winner),
        .winner_idx (winner_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        winner_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (winner[k]) begin
                winner_data = i_Data[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_Ser_Ready && any_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_Ser_Ready) begin
                    state_nxt = BUSY;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (i_Ser_Ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A falling ready sample wins over a coincident timeout: the serializer has taken the word.
    always_comb begin
        grant_pulse_nxt = '0;
        done_nxt        = '0;
        tmo_nxt         = 1'b0;
        data_ready_nxt  = 1'b0;
        load_word       = 1'b0;
        grant_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (i_Ser_Ready && any_valid) begin
                    grant_pulse_nxt = winner;
                    data_ready_nxt  = 1'b1;
                    load_word       = 1'b1;
                end
            end
            ISSUE: begin
                if (!i_Ser_Ready) begin
                    data_ready_nxt = 1'b0;
                end else if (tmo_hit) begin
                    tmo_nxt   = 1'b1;
                    grant_clr = 1'b1;
                end else begin
                    data_ready_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (i_Ser_Ready) begin
                    done_nxt  = grant_r;
                    grant_clr = 1'b1;
                end
            end
            default: begin
                grant_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Grant          <= '0;
            o_Done           <= '0;
            o_Timeout        <= 1'b0;
            o_Ser_Data_Ready <= 1'b0;
            o_Ser_Data       <= '0;
            grant_r          <= '0;
            last_r           <= PTR_W'(NUM_CH - 1);
            tmo_cnt          <= '0;
        end else begin
            o_Grant          <= grant_pulse_nxt;
            o_Done           <= done_nxt;
            o_Timeout        <= tmo_nxt;
            o_Ser_Data_Ready <= data_ready_nxt;
            if (load_word) begin
                o_Ser_Data <= winner_data;
                grant_r    <= winner;
                last_r     <= winner_idx;
                tmo_cnt    <= '0;
            end else begin
                if (grant_clr) begin
                    grant_r <= '0;
                end
                if (state == ISSUE) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

    // Only the owning channel sees the serializer's chip select; everyone else stays deselected.
    assign o_CS = ~grant_r | {NUM_CH{i_Ser_CS}};

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/ends from a round-robin reference; a monitor pops and compares.
module tb_spi_frame_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DW        = 32;
    localparam int TMO       = 32;
    localparam int FRAME_LEN = 8;

    logic                   clk = 1'b0;
    logic                   i_Reset;
    logic [NUM_CH-1:0]      i_Enable;
    logic [NUM_CH-1:0]      i_Req;
    logic [NUM_CH*DW-1:0]   i_Data;
    logic [NUM_CH-1:0]      o_Grant;
    logic [NUM_CH-1:0]      o_Done;
    logic                   o_Timeout;
    logic                   o_Ser_Data_Ready;
    logic [DW-1:0]          o_Ser_Data;
    logic                   ser_ready;
    logic                   ser_cs;
    logic [NUM_CH-1:0]      o_CS;

    always #5 clk = ~clk;

    spi_frame_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_SIZE (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .i_Clock          (clk),
        .i_Reset          (i_Reset),
        .i_Enable         (i_Enable),
        .i_Req            (i_Req),
        .i_Data           (i_Data),
        .o_Grant          (o_Grant),
        .o_Done           (o_Done),
        .o_Timeout        (o_Timeout),
        .o_Ser_Data_Ready (o_Ser_Data_Ready),
        .o_Ser_Data       (o_Ser_Data),
        .i_Ser_Ready      (ser_ready),
        .i_Ser_CS         (ser_cs),
        .o_CS             (o_CS)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        bit            tmo;
        bit            b2b;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   grant_cnt = 0;
    int   end_cnt = 0;
    int   cyc = 0;
    int   last_end_cyc = -100;
    int   drcnt = 0;
    bit   active = 0;
    bit   stall = 0;
    int   m_last = NUM_CH - 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic int pick(input logic [NUM_CH-1:0] elig, input int last);
        for (int i = 1; i <= NUM_CH; i++) begin
            int c = (last + i) % NUM_CH;
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH*DW-1:0] rand_data();
        logic [NUM_CH*DW-1:0] d;
        for (int k = 0; k < NUM_CH; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    // Serializer model: loads on ready&&load at an edge, then shifts FRAME_LEN cycles with CS low.
    initial begin
        ser_ready = 1'b1;
        ser_cs    = 1'b1;
        forever begin
            @(negedge clk);
            if (o_Ser_Data_Ready && ser_ready && !stall && !i_Reset) begin
                @(posedge clk);
                #1;
                ser_ready = 1'b0;
                ser_cs    = 1'b0;
                repeat (FRAME_LEN) @(posedge clk);
                #1;
                ser_cs    = 1'b1;
                ser_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] exp_cs;
        cyc++;
        if (i_Reset) begin
            exp_q.delete();
            active = 0;
        end else begin
            if (o_Grant != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=%b required=none", o_Grant);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_onehot", o_Grant, 128'(1) << cur.ch);
                    chk("grant_data", o_Ser_Data, cur.data);
                    if (cur.b2b) chk("b2b_gap", cyc - last_end_cyc, 1);
                    active = 1;
                    drcnt  = 0;
                end
                grant_cnt++;
            end
            if (o_Ser_Data_Ready) begin
                if (!active) chk("dr_without_grant", o_Ser_Data_Ready, 0);
                else begin
                    drcnt++;
                    if (o_Ser_Data !== cur.data) chk("data_stable", o_Ser_Data, cur.data);
                end
            end
            if (o_Done != '0 || o_Timeout) begin
                if (!active) chk("end_without_grant", {o_Done, o_Timeout}, 0);
                else if (cur.tmo) begin
                    chk("timeout_pulse", o_Timeout, 1);
                    chk("timeout_no_done", o_Done, 0);
                    chk("timeout_dr_cycles", drcnt, TMO);
                end else begin
                    chk("done_onehot", o_Done, 128'(1) << cur.ch);
                    chk("done_no_timeout", o_Timeout, 0);
                    chk("dr_cycles", drcnt, 2);
                end
                active = 0;
                end_cnt++;
                last_end_cyc = cyc;
            end
            exp_cs = '1;
            if (active) exp_cs[cur.ch] = ser_cs;
            chk("cs_route", o_CS, exp_cs);
        end
    end

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (grant_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("grant_wait", grant_cnt >= target, 1);
    endtask

    task automatic wait_ends(input int target, input int budget);
        int n = 0;
        while (end_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("end_wait", end_cnt >= target, 1);
    endtask

    task automatic run_burst(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] req,
                             input int n, input bit tmo, input logic [NUM_CH*DW-1:0] data);
        int g0, e0, w;
        i_Enable = en;
        i_Data   = data;
        for (int k = 0; k < n; k++) begin
            w = pick(req & en, m_last);
            m_last = w;
            exp_q.push_back('{w, data[w*DW +: DW], tmo, (k > 0)});
        end
        g0 = grant_cnt;
        e0 = end_cnt;
        i_Req = req;
        wait_grants(g0 + n, n * (TMO + 40));
        i_Req  = '0;
        i_Data = rand_data();
        wait_ends(e0 + n, n * (TMO + 40));
    endtask

    initial begin
        logic [NUM_CH*DW-1:0] d;
        logic [NUM_CH-1:0]    en, req;
        int g0, e0, n;

        i_Reset  = 1'b1;
        i_Req    = '0;
        i_Enable = '0;
        i_Data   = '0;
        repeat (3) @(posedge clk);
        #1 i_Reset = 1'b0;
        @(negedge clk);
        chk("rst_grant", o_Grant, 0);
        chk("rst_done", o_Done, 0);
        chk("rst_timeout", o_Timeout, 0);
        chk("rst_dr", o_Ser_Data_Ready, 0);
        chk("rst_data", o_Ser_Data, 0);
        chk("rst_cs", o_CS, 4'b1111);
        @(posedge clk);
        #1;

        d = rand_data();
        d[2*DW +: DW] = 32'hA5A5_0F0F;
        run_burst(4'b1111, 4'b0100, 1, 0, d);

        run_burst(4'b1111, 4'b1111, 5, 0, rand_data());
        run_burst(4'b1101, 4'b1111, 4, 0, rand_data());

        stall = 1;
        run_burst(4'b1111, 4'b0001 << $urandom_range(0, 3), 1, 1, rand_data());
        stall = 0;
        run_burst(4'b1111, 4'b0010, 1, 0, rand_data());

        // Reset while the serializer is mid-frame
        i_Enable = 4'b1111;
        i_Data   = rand_data();
        m_last   = pick(4'b0001, m_last);
        exp_q.push_back('{m_last, i_Data[m_last*DW +: DW], 1'b0, 1'b0});
        g0 = grant_cnt;
        i_Req = 4'b0001;
        wait_grants(g0 + 1, 40);
        i_Req = '0;
        repeat (2) @(posedge clk);
        #1 i_Reset = 1'b1;
        @(posedge clk);
        #1 i_Reset = 1'b0;
        m_last = NUM_CH - 1;
        @(negedge clk);
        chk("midreset_ser_cs_low", ser_cs, 0);
        chk("midreset_cs", o_CS, 4'b1111);
        chk("midreset_dr", o_Ser_Data_Ready, 0);
        i_Data = rand_data();
        exp_q.push_back('{3, i_Data[3*DW +: DW], 1'b0, 1'b0});
        m_last = 3;
        g0 = grant_cnt;
        e0 = end_cnt;
        i_Req = 4'b1000;
        n = 0;
        while (!ser_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_ready_back", ser_ready, 1);
        chk("midreset_no_early_grant", grant_cnt, g0);
        @(posedge clk);
        #1;
        wait_grants(g0 + 1, 40);
        i_Req = '0;
        wait_ends(e0 + 1, TMO + 40);

        run_burst(4'b1111, 4'b0010, 2, 0, rand_data());

        repeat (25) begin
            do begin
                en  = NUM_CH'($urandom);
                req = NUM_CH'($urandom);
            end while ((en & req) == '0);
            run_burst(en, req, $urandom_range(1, 3), 0, rand_data());
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
